mc_ctrl: RTL and testbench

Multi-cycle control unit for the MIPS core. It sequences each instruction through fetch, decode, execute, memory and write-back states. It drives the next-PC selector (NPCOp), the PC, IR, register-file and data-memory write enables, and the datapath mux selects. It sits beside the datapath, takes the IR opcode/funct fields and the ALU Zero flag, and is the only source of PC and state-element write strobes.

---
 rtl/mips_pkg.sv | 74 +++++++
 rtl/mc_decode.sv | 32 +++
 rtl/mc_ctrl.sv | 165 ++++++++++++++++
 tb/tb_mc_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: FSM states,
// opcode/funct constants, datapath select codes and the decoded instruction class.
package mips_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM_RD = 3'd3,
    S_MEM_WR = 3'd4,
    S_WB     = 3'd5,
    S_BR     = 3'd6,
    S_JMP    = 3'd7
  } state_e;

  typedef enum logic [3:0] {
    IC_RTYPE_ALU = 4'd0,
    IC_JR        = 4'd1,
    IC_ORI       = 4'd2,
    IC_LUI       = 4'd3,
    IC_LW        = 4'd4,
    IC_SW        = 4'd5,
    IC_BEQ       = 4'd6,
    IC_J         = 4'd7,
    IC_JAL       = 4'd8,
    IC_ILLEGAL   = 4'd9
  } iclass_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [1:0] NPC_PC4  = 2'b00;
  localparam logic [1:0] NPC_BR   = 2'b01;
  localparam logic [1:0] NPC_JUMP = 2'b10;
  localparam logic [1:0] NPC_REG  = 2'b11;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_OR   = 2'b10;
  localparam logic [1:0] ALU_LUI  = 2'b11;

  localparam logic [1:0] GPR_RT   = 2'b00;
  localparam logic [1:0] GPR_RD   = 2'b01;
  localparam logic [1:0] GPR_RA   = 2'b10;

  localparam logic [1:0] WD_ALU   = 2'b00;
  localparam logic [1:0] WD_MEM   = 2'b01;
  localparam logic [1:0] WD_LINK  = 2'b10;

  // Bundle of every control output, so a checker can bind to one signal.
  typedef struct packed {
    logic       pc_wr;
    logic [1:0] npc_op;
    logic       ir_wr;
    logic       rf_wr;
    logic       dm_wr;
    logic       ext_op;
    logic       alu_src;
    logic [1:0] alu_op;
    logic [1:0] gpr_sel;
    logic [1:0] wd_sel;
  } ctrl_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: maps Op/Funct onto the instruction
// class the control FSM sequences on.
module mc_decode
  import mips_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output iclass_e    cls
);

  always_comb begin
    cls = IC_ILLEGAL;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU, FN_SUBU: cls = IC_RTYPE_ALU;
          FN_JR:            cls = IC_JR;
          default:          cls = IC_ILLEGAL;
        endcase
      end
      OP_ORI:  cls = IC_ORI;
      OP_LUI:  cls = IC_LUI;
      OP_LW:   cls = IC_LW;
      OP_SW:   cls = IC_SW;
      OP_BEQ:  cls = IC_BEQ;
      OP_J:    cls = IC_J;
      OP_JAL:  cls = IC_JAL;
      default: cls = IC_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXE/MEM/WB/BR/JMP and
// drives all PC, IR, register-file and data-memory strobes plus datapath selects.
module mc_ctrl
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       PCWr,
  output logic [1:0] NPCOp,
  output logic       IRWr,
  output logic       RFWr,
  output logic       DMWr,
  output logic       ExtOp,
  output logic       ALUSrc,
  output logic [1:0] ALUOp,
  output logic [1:0] GPRSel,
  output logic [1:0] WDSel
);

  state_e     state_q, state_d;
  logic [5:0] op_q, op_d;
  logic [5:0] funct_q, funct_d;
  logic [5:0] dec_op, dec_funct;
  iclass_e    cls;
  ctrl_t      ctrl;

  // DECODE classifies the live IR fields; every later state uses the latched copy.
  assign dec_op    = (state_q == S_DECODE) ? Op    : op_q;
  assign dec_funct = (state_q == S_DECODE) ? Funct : funct_q;

  mc_decode u_decode (
    .op    (dec_op),
    .funct (dec_funct),
    .cls   (cls)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      funct_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      funct_q <= funct_d;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    op_d    = op_q;
    funct_d = funct_q;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        op_d    = Op;
        funct_d = Funct;
        case (cls)
          IC_BEQ:                       state_d = S_BR;
          IC_J, IC_JAL, IC_JR:          state_d = S_JMP;
          IC_RTYPE_ALU, IC_ORI, IC_LUI,
          IC_LW, IC_SW:                 state_d = S_EXE;
          default:                      state_d = S_FETCH;
        endcase
      end
      S_EXE: begin
        case (cls)
          IC_LW:   state_d = S_MEM_RD;
          IC_SW:   state_d = S_MEM_WR;
          default: state_d = S_WB;
        endcase
      end
      S_MEM_RD: state_d = S_WB;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.ir_wr  = 1'b1;
        ctrl.pc_wr  = 1'b1;
        ctrl.npc_op = NPC_PC4;
      end
      S_EXE: begin
        case (cls)
          IC_LW, IC_SW: begin
            ctrl.alu_src = 1'b1;
            ctrl.ext_op  = 1'b1;
            ctrl.alu_op  = ALU_ADD;
          end
          IC_ORI: begin
            ctrl.alu_src = 1'b1;
            ctrl.ext_op  = 1'b0;
            ctrl.alu_op  = ALU_OR;
          end
          IC_LUI: begin
            ctrl.alu_src = 1'b1;
            ctrl.alu_op  = ALU_LUI;
          end
          IC_RTYPE_ALU: begin
            ctrl.alu_op = (funct_q == FN_SUBU) ? ALU_SUB : ALU_ADD;
          end
          default: ;
        endcase
      end
      S_MEM_WR: ctrl.dm_wr = 1'b1;
      S_WB: begin
        ctrl.rf_wr = 1'b1;
        case (cls)
          IC_RTYPE_ALU: begin
            ctrl.gpr_sel = GPR_RD;
            ctrl.wd_sel  = WD_ALU;
          end
          IC_LW: begin
            ctrl.gpr_sel = GPR_RT;
            ctrl.wd_sel  = WD_MEM;
          end
          default: begin
            ctrl.gpr_sel = GPR_RT;
            ctrl.wd_sel  = WD_ALU;
          end
        endcase
      end
      S_BR: begin
        ctrl.alu_op  = ALU_SUB;
        ctrl.alu_src = 1'b0;
        ctrl.npc_op  = NPC_BR;
        ctrl.pc_wr   = Zero;
      end
      S_JMP: begin
        ctrl.pc_wr = 1'b1;
        case (cls)
          IC_JAL: begin
            ctrl.npc_op  = NPC_JUMP;
            ctrl.rf_wr   = 1'b1;
            ctrl.gpr_sel = GPR_RA;
            ctrl.wd_sel  = WD_LINK;
          end
          IC_JR:   ctrl.npc_op = NPC_REG;
          default: ctrl.npc_op = NPC_JUMP;
        endcase
      end
      default: ;
    endcase
    // Reset kills every strobe combinationally, so an aborted store never lands.
    if (rst) ctrl = '0;
  end

  assign PCWr   = ctrl.pc_wr;
  assign NPCOp  = ctrl.npc_op;
  assign IRWr   = ctrl.ir_wr;
  assign RFWr   = ctrl.rf_wr;
  assign DMWr   = ctrl.dm_wr;
  assign ExtOp  = ctrl.ext_op;
  assign ALUSrc = ctrl.alu_src;
  assign ALUOp  = ctrl.alu_op;
  assign GPRSel = ctrl.gpr_sel;
  assign WDSel  = ctrl.wd_sel;

endmodule

// File: tb/tb_mc_ctrl.sv
// Table-driven bench for mc_ctrl: per-cycle expected control words are queued
// as stimulus is driven and compared at the falling edge.
module tb_mc_ctrl;

  logic       clk;
  logic       rst;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       PCWr;
  logic [1:0] NPCOp;
  logic       IRWr;
  logic       RFWr;
  logic       DMWr;
  logic       ExtOp;
  logic       ALUSrc;
  logic [1:0] ALUOp;
  logic [1:0] GPRSel;
  logic [1:0] WDSel;

  mc_ctrl dut (
    .clk    (clk),
    .rst    (rst),
    .Op     (Op),
    .Funct  (Funct),
    .Zero   (Zero),
    .PCWr   (PCWr),
    .NPCOp  (NPCOp),
    .IRWr   (IRWr),
    .RFWr   (RFWr),
    .DMWr   (DMWr),
    .ExtOp  (ExtOp),
    .ALUSrc (ALUSrc),
    .ALUOp  (ALUOp),
    .GPRSel (GPRSel),
    .WDSel  (WDSel)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // control word: {PCWr, NPCOp, IRWr, RFWr, DMWr, ExtOp, ALUSrc, ALUOp, GPRSel, WDSel}
  typedef struct {
    string            name;
    logic [5:0]       op;
    logic [5:0]       funct;
    logic             zero;
    int               n;
    logic [4:0][13:0] exp;
  } vec_t;

  logic [13:0] exp_q[$];
  int n_vec  = 0;
  int n_miss = 0;
  vec_t tbl[13];

  function automatic logic [13:0] mk(input logic pcwr, input logic [1:0] npc,
                                     input logic irwr, input logic rfwr, input logic dmwr,
                                     input logic ext, input logic asrc, input logic [1:0] aop,
                                     input logic [1:0] gpr, input logic [1:0] wd);
    return {pcwr, npc, irwr, rfwr, dmwr, ext, asrc, aop, gpr, wd};
  endfunction

  function automatic vec_t mkv(input string nm, input logic [5:0] op, input logic [5:0] fn,
                               input logic z, input int n,
                               input logic [13:0] e0, input logic [13:0] e1,
                               input logic [13:0] e2, input logic [13:0] e3,
                               input logic [13:0] e4);
    vec_t v;
    v.name  = nm;
    v.op    = op;
    v.funct = fn;
    v.zero  = z;
    v.n     = n;
    v.exp   = {e4, e3, e2, e1, e0};
    return v;
  endfunction

  // scoreboard
  task automatic compare(input string nm);
    logic [13:0] act;
    logic [13:0] e;
    act = {PCWr, NPCOp, IRWr, RFWr, DMWr, ExtOp, ALUSrc, ALUOp, GPRSel, WDSel};
    n_vec++;
    if (exp_q.size() == 0) begin
      n_miss++;
      $display("FAIL %s: scoreboard empty, got %b", nm, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        n_miss++;
        $display("FAIL %s: got %b expected %b", nm, act, e);
      end
    end
  endtask

  // driver: enters just after a rising edge, leaves just after a rising edge
  task automatic run_vec(input vec_t v, input int ncyc, input bit late_beq);
    for (int c = 0; c < ncyc; c++) begin
      if (c <= 1) begin
        Op    = v.op;
        Funct = v.funct;
      end else if (late_beq) begin
        Op    = 6'b000100;
        Funct = 6'($urandom_range(0, 63));
      end else begin
        Op    = 6'($urandom_range(0, 63));
        Funct = 6'($urandom_range(0, 63));
      end
      Zero = (c == 2) ? v.zero : 1'($urandom_range(0, 1));
      exp_q.push_back(v.exp[c]);
      @(negedge clk);
      compare($sformatf("%s_c%0d", v.name, c + 1));
      @(posedge clk);
      #1;
    end
  endtask

  logic [13:0] F, D, Z;

  initial begin
    rst = 1'b1; Op = '0; Funct = '0; Zero = 1'b0;
    F = mk(1, 2'd0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0);
    D = '0;
    Z = '0;
    tbl[0]  = mkv("addu", 6'b000000, 6'b100001, 0, 4, F, D, Z,
                  mk(0, 0, 0, 1, 0, 0, 0, 2'd0, 2'd1, 2'd0), Z);
    tbl[1]  = mkv("subu", 6'b000000, 6'b100011, 0, 4, F, D,
                  mk(0, 0, 0, 0, 0, 0, 0, 2'd1, 2'd0, 2'd0),
                  mk(0, 0, 0, 1, 0, 0, 0, 2'd0, 2'd1, 2'd0), Z);
    tbl[2]  = mkv("ori", 6'b001101, 6'd0, 0, 4, F, D,
                  mk(0, 0, 0, 0, 0, 0, 1, 2'd2, 2'd0, 2'd0),
                  mk(0, 0, 0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0), Z);
    tbl[3]  = mkv("lui", 6'b001111, 6'd0, 0, 4, F, D,
                  mk(0, 0, 0, 0, 0, 0, 1, 2'd3, 2'd0, 2'd0),
                  mk(0, 0, 0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0), Z);
    tbl[4]  = mkv("lw", 6'b100011, 6'd0, 0, 5, F, D,
                  mk(0, 0, 0, 0, 0, 1, 1, 2'd0, 2'd0, 2'd0), Z,
                  mk(0, 0, 0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd1));
    tbl[5]  = mkv("sw", 6'b101011, 6'd0, 0, 4, F, D,
                  mk(0, 0, 0, 0, 0, 1, 1, 2'd0, 2'd0, 2'd0),
                  mk(0, 0, 0, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0), Z);
    tbl[6]  = mkv("beq_taken", 6'b000100, 6'd0, 1, 3, F, D,
                  mk(1, 2'd1, 0, 0, 0, 0, 0, 2'd1, 2'd0, 2'd0), Z, Z);
    tbl[7]  = mkv("beq_not", 6'b000100, 6'd0, 0, 3, F, D,
                  mk(0, 2'd1, 0, 0, 0, 0, 0, 2'd1, 2'd0, 2'd0), Z, Z);
    tbl[8]  = mkv("j", 6'b000010, 6'd0, 0, 3, F, D,
                  mk(1, 2'd2, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0), Z, Z);
    tbl[9]  = mkv("jal", 6'b000011, 6'd0, 0, 3, F, D,
                  mk(1, 2'd2, 0, 1, 0, 0, 0, 2'd0, 2'd2, 2'd2), Z, Z);
    tbl[10] = mkv("jr", 6'b000000, 6'b001000, 0, 3, F, D,
                  mk(1, 2'd3, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0), Z, Z);
    tbl[11] = mkv("illegal_op", 6'b111111, 6'd0, 0, 2, F, D, Z, Z, Z);
    tbl[12] = mkv("bad_funct", 6'b000000, 6'b000000, 0, 2, F, D, Z, Z, Z);

    // reset held three cycles: everything quiet
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      Op = 6'b100011;
      exp_q.push_back(Z);
      @(negedge clk);
      compare($sformatf("reset_c%0d", i));
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_vec(tbl[4], tbl[4].n, 1'b0);

    // every table entry in order, then a random mix
    for (int i = 0; i < 13; i++) run_vec(tbl[i], tbl[i].n, 1'b0);
    for (int k = 0; k < 40; k++) begin
      int idx;
      idx = $urandom_range(0, 12);
      run_vec(tbl[idx], tbl[idx].n, 1'b0);
    end

    // addu whose Op turns into beq after DECODE still completes as addu
    run_vec(tbl[0], tbl[0].n, 1'b1);

    // reset asserted in MEM_WR of sw: DMWr must drop without waiting for a clock
    run_vec(tbl[5], 3, 1'b0);
    exp_q.push_back(tbl[5].exp[3]);
    @(negedge clk);
    compare("sw_memwr_pre_rst");
    #2;
    rst = 1'b1;
    #1;
    exp_q.push_back(Z);
    compare("sw_rst_async");
    @(posedge clk);
    #1;
    exp_q.push_back(Z);
    @(negedge clk);
    compare("sw_rst_hold");
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_vec(tbl[2], tbl[2].n, 1'b0);
    run_vec(tbl[9], tbl[9].n, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
